// File: rtl/tx_fifo_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART TX FIFO between two producers.
// Define TX_ARB_LEN_CHECK_EN to enforce the announced frame length against the bytes written.
module tx_fifo_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned MARGIN     = 48,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        clr_err,

    input  logic        req0,
    input  logic [9:0]  len0,
    input  logic        wen0,
    input  logic [7:0]  wdata0,
    input  logic        last0,
    output logic        gnt0,

    input  logic        req1,
    input  logic [9:0]  len1,
    input  logic        wen1,
    input  logic [7:0]  wdata1,
    input  logic        last1,
    output logic        gnt1,

    output logic        tx_fifo_wen,
    output logic [7:0]  tx_fifo_wdata,
    input  logic        tx_fifo_full,
    input  logic [11:0] tx_fifo_usedw,

    output logic        busy,
    output logic        ovf_err,
    output logic        drop_err,
    output logic        len_err
);

    localparam logic [12:0] DepthW  = 13'(FIFO_DEPTH);
    localparam logic [12:0] MarginW = 13'(MARGIN);
    localparam logic [3:0]  GapLast = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StXfer, StGap} state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        ptr_q, ptr_d;
    logic [9:0]  len_q, len_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        space_ok_q, space_ok_d;
    logic        wen_q, wen_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ovf_q, ovf_d;
    logic        drop_q, drop_d;
    logic        ovf_set, drop_set;

    logic        req_sel, wen_sel, last_sel;
    logic [7:0]  wdata_sel;
    logic [12:0] free_space, need_space;

`ifdef TX_ARB_LEN_CHECK_EN
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  cnt_inc;
    logic        len_err_q, len_err_d;
    logic        len_set;
`endif

    assign gnt0 = (state_q == StXfer) && !sel_q;
    assign gnt1 = (state_q == StXfer) && sel_q;
    assign busy = (state_q != StIdle);

    assign req_sel   = sel_q ? req1   : req0;
    assign wen_sel   = sel_q ? wen1   : wen0;
    assign last_sel  = sel_q ? last1  : last0;
    assign wdata_sel = sel_q ? wdata1 : wdata0;

    // Space check is pipelined one cycle; it tracks len_d so a freshly latched
    // length is already reflected when CHECK first evaluates it.
    assign free_space = DepthW - {1'b0, tx_fifo_usedw};
    assign need_space = {3'b000, len_d} + MarginW;
    assign space_ok_d = (len_d == 10'd0) || (free_space >= need_space);

`ifdef TX_ARB_LEN_CHECK_EN
    assign cnt_inc = cnt_q + 10'd1;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        gap_cnt_d = gap_cnt_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        ovf_set   = 1'b0;
        drop_set  = (wen0 && !gnt0) || (wen1 && !gnt1);
`ifdef TX_ARB_LEN_CHECK_EN
        cnt_d     = cnt_q;
        len_set   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (ena && (req0 || req1)) begin
                    if (ptr_q) begin
                        sel_d = req1 ? 1'b1 : 1'b0;
                    end else begin
                        sel_d = req0 ? 1'b0 : 1'b1;
                    end
                    len_d   = sel_d ? len1 : len0;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                if (!req_sel) begin
                    state_d = StIdle;
                end else if (space_ok_q) begin
                    state_d = StXfer;
`ifdef TX_ARB_LEN_CHECK_EN
                    cnt_d   = 10'd0;
`endif
                end
            end

            StXfer: begin
                if (wen_sel) begin
                    wdata_d = wdata_sel;
                    wen_d   = !tx_fifo_full;
                    ovf_set = tx_fifo_full;
`ifdef TX_ARB_LEN_CHECK_EN
                    cnt_d   = cnt_inc;
                    if (last_sel) begin
                        if ((len_q != 10'd0) && (cnt_inc < len_q)) begin
                            len_set = 1'b1;
                        end
                        state_d   = StGap;
                        gap_cnt_d = 4'd0;
                        ptr_d     = !sel_q;
                    end else if ((len_q != 10'd0) && (cnt_inc == len_q)) begin
                        // Announced length exhausted without last: cut the grant.
                        len_set   = 1'b1;
                        state_d   = StGap;
                        gap_cnt_d = 4'd0;
                        ptr_d     = !sel_q;
                    end
`else
                    if (last_sel) begin
                        state_d   = StGap;
                        gap_cnt_d = 4'd0;
                        ptr_d     = !sel_q;
                    end
`endif
                end
            end

            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: state_d = StIdle;
        endcase

        // A new error event wins over a coincident clear.
        ovf_d  = (ovf_q && !clr_err) || ovf_set;
        drop_d = (drop_q && !clr_err) || drop_set;
`ifdef TX_ARB_LEN_CHECK_EN
        len_err_d = (len_err_q && !clr_err) || len_set;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            ptr_q      <= 1'b0;
            len_q      <= 10'd0;
            gap_cnt_q  <= 4'd0;
            space_ok_q <= 1'b0;
            wen_q      <= 1'b0;
            wdata_q    <= 8'd0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            gap_cnt_q  <= gap_cnt_d;
            space_ok_q <= space_ok_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

`ifdef TX_ARB_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 10'd0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign tx_fifo_wen   = wen_q;
    assign tx_fifo_wdata = wdata_q;
    assign ovf_err       = ovf_q;
    assign drop_err      = drop_q;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter; honours TX_ARB_LEN_CHECK_EN when defined.
module tb_tx_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, clr_err;
    logic        req0, wen0, last0, gnt0;
    logic [9:0]  len0;
    logic [7:0]  wdata0;
    logic        req1, wen1, last1, gnt1;
    logic [9:0]  len1;
    logic [7:0]  wdata1;
    logic        tx_fifo_wen, tx_fifo_full;
    logic [7:0]  tx_fifo_wdata;
    logic [11:0] tx_fifo_usedw;
    logic        busy, ovf_err, drop_err, len_err;

    int n_cmp = 0;
    int n_err = 0;
    int nwr   = 0;
    int w0;

    tx_fifo_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .clr_err       (clr_err),
        .req0          (req0),
        .len0          (len0),
        .wen0          (wen0),
        .wdata0        (wdata0),
        .last0         (last0),
        .gnt0          (gnt0),
        .req1          (req1),
        .len1          (len1),
        .wen1          (wen1),
        .wdata1        (wdata1),
        .last1         (last1),
        .gnt1          (gnt1),
        .tx_fifo_wen   (tx_fifo_wen),
        .tx_fifo_wdata (tx_fifo_wdata),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_usedw (tx_fifo_usedw),
        .busy          (busy),
        .ovf_err       (ovf_err),
        .drop_err      (drop_err),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_fifo_wen === 1'b1) nwr++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int p, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = (p != 0) ? gnt1 : gnt0;
        end
        check(tag, {31'd0, seen}, 32'd1);
        if (seen) check({tag, "_other"}, (p != 0) ? {31'd0, gnt0} : {31'd0, gnt1}, 32'd0);
        if (p != 0) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic send(input int p, input int n, input logic [7:0] base, input bit with_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            if (p != 0) begin
                wen1 = 1'b1; wdata1 = d; last1 = with_last && (i == n - 1);
            end else begin
                wen0 = 1'b1; wdata0 = d; last0 = with_last && (i == n - 1);
            end
            tick();
            check("fwd_wen", {31'd0, tx_fifo_wen}, 32'd1);
            check("fwd_data", {24'd0, tx_fifo_wdata}, {24'd0, d});
        end
        wen0 = 1'b0; last0 = 1'b0; wen1 = 1'b0; last1 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; clr_err = 1'b0;
        req0 = 1'b0; len0 = 10'd0; wen0 = 1'b0; wdata0 = 8'd0; last0 = 1'b0;
        req1 = 1'b0; len1 = 10'd0; wen1 = 1'b0; wdata1 = 8'd0; last1 = 1'b0;
        tx_fifo_full = 1'b0; tx_fifo_usedw = 12'd0;
        tick(); tick();
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_wen", {31'd0, tx_fifo_wen}, 32'd0);
        check("rst_wdata", {24'd0, tx_fifo_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {29'd0, ovf_err, drop_err, len_err}, 32'd0);
        rst = 1'b1;
        tick();

        // Single frame with ample space: grant two cycles after req0.
        req0 = 1'b1; len0 = 10'd72;
        tick();
        check("t1_gnt_c1", {31'd0, gnt0}, 32'd0);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("t1_gnt_c2", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        w0 = nwr;
        send(0, 72, 8'h01, 1'b1);
        check("t1_gnt_after_last", {31'd0, gnt0}, 32'd0);
        check("t1_busy_gap", {31'd0, busy}, 32'd1);
        tick();
        check("t1_wen_idle", {31'd0, tx_fifo_wen}, 32'd0);
        tick(); tick();
        check("t1_busy_gap3", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        check("t1_nwrites", nwr - w0, 32'd72);

        // Simultaneous requests after reset: 0, 1, then 0 again.
        rst = 1'b0; tick(); rst = 1'b1; tick();
        req0 = 1'b1; req1 = 1'b1; len0 = 10'd4; len1 = 10'd4;
        wait_gnt(0, "t2_first_p0");
        send(0, 4, 8'h10, 1'b1);
        wait_gnt(1, "t2_then_p1");
        send(1, 4, 8'h20, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(0, "t2_again_p0");
        send(0, 4, 8'h30, 1'b1);
        wait_gnt(1, "t2_again_p1");
        send(1, 4, 8'h38, 1'b1);

        // Space wait: free 118 < 120 holds off; 120 grants two cycles later.
        tx_fifo_usedw = 12'd1930; req0 = 1'b1; len0 = 10'd72;
        for (int i = 0; i < 8; i++) tick();
        check("t3_no_gnt", {31'd0, gnt0}, 32'd0);
        check("t3_busy_wait", {31'd0, busy}, 32'd1);
        tx_fifo_usedw = 12'd1928;
        tick();
        check("t3_gnt_c1", {31'd0, gnt0}, 32'd0);
        tick();
        check("t3_gnt_c2", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0; tx_fifo_usedw = 12'd0;
        send(0, 72, 8'h40, 1'b1);

        // Error flags.
        req0 = 1'b1; len0 = 10'd4;
        wait_gnt(0, "t4_gnt");
        wen1 = 1'b1; wdata1 = 8'hff;
        tick();
        wen1 = 1'b0;
        check("t4_drop_nowrite", {31'd0, tx_fifo_wen}, 32'd0);
        check("t4_drop_err", {31'd0, drop_err}, 32'd1);
        check("t4_ovf_clear", {31'd0, ovf_err}, 32'd0);
        tx_fifo_full = 1'b1; wen0 = 1'b1; wdata0 = 8'haa;
        tick();
        wen0 = 1'b0; tx_fifo_full = 1'b0;
        check("t4_ovf_nowrite", {31'd0, tx_fifo_wen}, 32'd0);
        check("t4_ovf_err", {31'd0, ovf_err}, 32'd1);
        send(0, 3, 8'h50, 1'b1);
        check("t4_len_err_ok", {31'd0, len_err}, 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr_flags", {29'd0, ovf_err, drop_err, len_err}, 32'd0);
        clr_err = 1'b1; wen1 = 1'b1;
        tick();
        clr_err = 1'b0; wen1 = 1'b0;
        check("t4_set_wins", {31'd0, drop_err}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr_again", {31'd0, drop_err}, 32'd0);

        // Reset mid-frame after byte 10 of 72; ptr is 1 here and must return to 0.
        req0 = 1'b1; len0 = 10'd72;
        wait_gnt(0, "t5_gnt");
        send(0, 10, 8'h60, 1'b0);
        rst = 1'b0;
        #1;
        check("t5_gnt_rst", {31'd0, gnt0}, 32'd0);
        check("t5_wen_rst", {31'd0, tx_fifo_wen}, 32'd0);
        check("t5_busy_rst", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_idle", {31'd0, busy}, 32'd0);
        req0 = 1'b1; req1 = 1'b1; len0 = 10'd4; len1 = 10'd4;
        wait_gnt(0, "t5_ptr0_p0");
        send(0, 4, 8'h70, 1'b1);
        wait_gnt(1, "t5_ptr0_p1");
        send(1, 4, 8'h78, 1'b1);

        // Frame longer than announced: len0=8, ten bytes with last on the tenth.
        req0 = 1'b1; len0 = 10'd8;
        wait_gnt(0, "t6_gnt");
        w0 = nwr;
        for (int i = 0; i < 10; i++) begin
            wen0 = 1'b1; wdata0 = 8'h80 + 8'(i); last0 = (i == 9);
            tick();
        end
        wen0 = 1'b0; last0 = 1'b0;
        tick(); tick();
`ifdef TX_ARB_LEN_CHECK_EN
        check("t6_nwrites", nwr - w0, 32'd8);
        check("t6_len_err", {31'd0, len_err}, 32'd1);
        check("t6_drop_err", {31'd0, drop_err}, 32'd1);
`else
        check("t6_nwrites", nwr - w0, 32'd10);
        check("t6_len_err", {31'd0, len_err}, 32'd0);
        check("t6_drop_err", {31'd0, drop_err}, 32'd0);
`endif
        check("t6_gnt_end", {31'd0, gnt0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
- Shares one UART TX byte FIFO between two frame producers, e.g. the acquisition frame builder and a status/reply builder.
- Grants are given per whole frame, round-robin.
- A grant is issued only after FIFO free space covers the announced frame length plus a margin, so frames are never interleaved or split by backpressure.
- Sits between the producers and the TX FIFO write port, clocked on the system clock.

Parameters:
- FIFO_DEPTH, 2048, TX FIFO capacity in bytes.
- MARGIN, 48, bytes kept free beyond the requested length before granting.
- GAP_CYCLES, 4, idle cycles inserted after each frame before the next arbitration (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- ena  input  1  arbitration enable
- clr_err  input  1  synchronous clear of the sticky error flags
- req0  input  1  producer 0 has a frame pending; held until granted
- len0  input  10  producer 0 frame length in bytes, stable while req0=1
- wen0  input  1  producer 0 byte write strobe
- wdata0  input  8  producer 0 byte
- last0  input  1  marks the final byte of producer 0's frame, qualified by wen0
- gnt0  output  1  producer 0 owns the FIFO
- req1, len1, wen1, wdata1, last1, gnt1: same as above for producer 1
- tx_fifo_wen  output  1  FIFO write strobe
- tx_fifo_wdata  output  8  FIFO write data
- tx_fifo_full  input  1  FIFO full
- tx_fifo_usedw  input  12  FIFO fill level
- busy  output  1  high in any state other than IDLE
- ovf_err  output  1  sticky: a write was attempted while the FIFO was full
- drop_err  output  1  sticky: a non-granted producer asserted wen
- len_err  output  1  sticky length mismatch; only used with the optional feature, otherwise tied 0

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer ptr=0, all counters 0.

State IDLE:
- Entered when ena=1 and (req0|req1).
- Selects the requester: ptr=0 favours req0, ptr=1 favours req1; the other wins if only it requests.
- Latches the selected length into len_q and goes to CHECK.
- With ena=0, stays in IDLE.

State CHECK:
- free = FIFO_DEPTH - tx_fifo_usedw, computed at 13 bits.
- If free >= len_q + MARGIN (13-bit compare), goes to XFER and asserts gnt of the selected producer in the next cycle.
- len_q=0 grants without the space check.
- If the selected req drops, returns to IDLE with no grant.
- Otherwise waits indefinitely.

State XFER:
- Exactly one gnt is high.
- Forwarding is registered with 1-cycle latency: tx_fifo_wen <= wenX & ~tx_fifo_full and tx_fifo_wdata <= wdataX, where X is the granted producer.
- wenX while tx_fifo_full=1: the byte is suppressed and ovf_err is set.
- wen from the non-granted producer is ignored and sets drop_err.
- wenX & lastX:
  - that byte is forwarded;
  - gnt clears the next cycle;
  - ptr is set to the other producer;
  - state moves to GAP.
- ena falling during XFER does not truncate the frame.

State GAP:
- Counts GAP_CYCLES cycles, then returns to IDLE.
- No req is sampled during GAP.

Other rules:
- tx_fifo_wen is low in every state except in the cycle following a qualified write.
- clr_err clears ovf_err, drop_err and len_err. If clr_err coincides with a new error event, the set wins.
- Asserting rst mid-frame clears gnt immediately; the partial frame is abandoned.

Optional Feature:
- Macro: TX_ARB_LEN_CHECK_EN.

With the macro defined:
- A 10-bit byte counter runs in XFER and is cleared on entry.
- When the counter reaches len_q without last: grant ends, len_err is set, state moves to GAP, and further writes from that producer set drop_err.
- When last arrives with count+1 < len_q: len_err is set; the frame still ends normally.
- len_q=0: the check is skipped.

Without the macro:
- No counter; only last ends a frame.
- len_q is used only for the space check.
- len_err is tied 0.

Test Plan:
- Single frame, space available: usedw=0, req0=1, len0=72, producer writes 72 bytes with last on byte 72 -> gnt0 2 cycles after req0; 72 FIFO writes, each 1 cycle after wen0, data identical; gnt0 low the cycle after last; busy low after GAP_CYCLES+1 cycles.
- Simultaneous requests: req0=req1=1 after reset -> producer 0 granted first, then producer 1; a second simultaneous request pair -> producer 0 first again, since ptr=0 after producer 1's frame.
- Space wait: usedw=1930, len0=72 -> no grant (free 118 < 120); usedw drops to 1928 -> gnt0 asserted 2 cycles later.
- Errors: wen1 during gnt0 -> drop_err=1, no FIFO write; tx_fifo_full=1 with wen0 -> no write, ovf_err=1; clr_err pulse -> all flags 0.
- Reset mid-frame: rst low after byte 10 of 72 -> gnt0=0 and tx_fifo_wen=0 immediately; after release, state IDLE and ptr=0.
- TX_ARB_LEN_CHECK_EN: len0=8, producer sends 10 bytes with last on byte 10 -> exactly 8 FIFO writes, len_err=1, drop_err=1.
